// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, single outstanding imem read, one-deep buffer,
// branch redirect with stale-response squash. Optional FETCH_PERF_EN adds perf counters.
`ifndef WIDTH
`define WIDTH 32
`endif

module fetch_unit #(
    parameter int                WIDTH    = `WIDTH,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [WIDTH-1:0]  imem_rdata,
    output logic [WIDTH-1:0]  inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              halted,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              fetch_halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              squash;
    logic              xfer;

    assign xfer      = inst_valid & inst_ready;
    // Request is a pure decode of the state register, masked while reset is held.
    assign imem_req  = !rst && (state == S_REQ);
    assign imem_addr = imem_req ? pc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            squash       <= 1'b0;
            inst         <= '0;
            inst_pc      <= '0;
            inst_valid   <= 1'b0;
            fetch_halted <= 1'b0;
`ifdef FETCH_PERF_EN
            perf_fetched  <= '0;
            perf_squashed <= '0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    state <= S_WAIT;
                    if (branch_taken) begin
                        pc     <= branch_target;
                        squash <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                        if (imem_valid) begin
                            squash <= 1'b0;
                            state  <= S_REQ;
`ifdef FETCH_PERF_EN
                            perf_squashed <= perf_squashed + 32'd1;
`endif
                        end else begin
                            squash <= 1'b1;
                        end
                    end else if (imem_valid) begin
                        if (squash) begin
                            squash <= 1'b0;
                            state  <= S_REQ;
`ifdef FETCH_PERF_EN
                            perf_squashed <= perf_squashed + 32'd1;
`endif
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A redirect wins over HALT even if the decoder takes the word this cycle.
                    if (branch_taken) begin
                        inst_valid <= 1'b0;
                        pc         <= branch_target;
                        state      <= S_REQ;
`ifdef FETCH_PERF_EN
                        if (xfer) perf_fetched  <= perf_fetched + 32'd1;
                        else      perf_squashed <= perf_squashed + 32'd1;
`endif
                    end else if (xfer) begin
                        inst_valid <= 1'b0;
`ifdef FETCH_PERF_EN
                        perf_fetched <= perf_fetched + 32'd1;
`endif
                        if (halted) begin
                            state        <= S_HALT;
                            fetch_halted <= 1'b1;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
